// File: rtl/j1_irq_ctrl_if.sv
// j1_irq_ctrl_if: J1 I/O bus as seen by one memory-mapped peripheral.
// Latency: none, plain wires; read data is combinational in the peripheral.
// Backpressure: none, the J1 bus has no wait states.
interface j1_irq_ctrl_if;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] dout;
    logic [15:0] din;
    logic        sel;

    // CPU side drives strobes, address and write data
    modport master (output rd, wr, addr, dout, input din, sel);
    // Peripheral side returns read data and its address-hit flag
    modport slave  (input rd, wr, addr, dout, output din, sel);
endinterface

// File: rtl/j1_irq_ctrl.sv
// j1_irq_ctrl: edge-capturing, masked, lowest-index-first interrupt controller on the J1 I/O bus.
// Latency: event sampled at edge e0 -> pending after e2 -> int_req pulse after e3; io_din combinational.
// Backpressure: none on the bus; after a pulse, further requests wait for an EOI write plus one gap cycle.
// Optional periodic timer on source 0 is compiled in with `define J1_IRQ_TIMER_EN.
module j1_irq_ctrl #(
    parameter int          NSRC      = 8,
    parameter logic [15:0] BASE_ADDR = 16'hC000
) (
    input  logic            sys_clk_i,
    input  logic            sys_rst_i,
    input  logic [NSRC-1:0] irq_src,
    j1_irq_ctrl_if.slave    io,
    output logic            int_req
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FIRE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [NSRC-1:0] sync1, sync2, prev, rise;
    logic [NSRC-1:0] pending, mask, eoi_clr, active;
    logic            gie;
    logic [1:0]      state;
    logic [3:0]      vector, first_idx;
    logic            sel, wr_hit, eoi_wr, in_service, tmr_evt;
    logic [2:0]      offset;
    logic [15:0]     rd_data;

    assign sel        = (io.addr[15:4] == BASE_ADDR[15:4]);
    assign offset     = io.addr[3:1];
    assign wr_hit     = io.wr & sel;
    assign eoi_wr     = wr_hit && (offset == 3'd2);
    assign eoi_clr    = eoi_wr ? io.dout[NSRC-1:0] : '0;
    assign active     = pending & mask;
    assign in_service = (state == ST_FIRE) || (state == ST_WAIT);

    // Reads are side-effect free and io_din is decoded from the address alone,
    // so the read strobe and the byte-address bit carry no information here.
    logic unused_bits;
    assign unused_bits = ^{io.rd, io.addr[0], io.dout};

`ifdef J1_IRQ_TIMER_EN
    logic [15:0] tmr_reload, tmr_count;

    // A zero reload parks the counter; at zero it reloads and flags one event.
    assign tmr_evt = (tmr_reload != 16'd0) && (tmr_count == 16'd0);

    // Periodic down-counter; writing the reload value restarts the period.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            tmr_reload <= 16'd0;
            tmr_count  <= 16'd0;
        end else if (wr_hit && (offset == 3'd5)) begin
            tmr_reload <= io.dout;
            tmr_count  <= io.dout;
        end else if (tmr_reload != 16'd0) begin
            tmr_count <= (tmr_count == 16'd0) ? tmr_reload : tmr_count - 16'd1;
        end
    end
`else
    assign tmr_evt = 1'b0;
`endif

    // Rising-edge detect after the synchroniser; the timer event is already synchronous.
    always_comb begin
        rise    = sync2 & ~prev;
        rise[0] = rise[0] | tmr_evt;
    end

    // Lowest enabled pending index wins.
    always_comb begin
        first_idx = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) first_idx = 4'(i);
        end
    end

    // Synchronise sources and latch events; a new edge beats a same-cycle EOI clear.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            pending <= '0;
        end else begin
            sync1   <= irq_src;
            sync2   <= sync1;
            prev    <= sync2;
            pending <= (pending & ~eoi_clr) | rise;
        end
    end

    // Firmware-writable mask and global enable.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            mask <= '0;
            gie  <= 1'b0;
        end else begin
            if (wr_hit && (offset == 3'd1)) mask <= io.dout[NSRC-1:0];
            if (wr_hit && (offset == 3'd4)) gie  <= io.dout[0];
        end
    end

    // Service sequencer: one-cycle request, hold until EOI, then a guaranteed idle gap.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state   <= ST_IDLE;
            int_req <= 1'b0;
            vector  <= 4'd0;
        end else begin
            int_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gie && (|active)) begin
                        vector  <= first_idx;
                        int_req <= 1'b1;
                        state   <= ST_FIRE;
                    end
                end
                ST_FIRE: state <= ST_WAIT;
                ST_WAIT: if (eoi_wr) state <= ST_GAP;
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Register read mux; unmapped, write-only and compiled-out offsets read zero.
    always_comb begin
        rd_data = 16'h0000;
        case (offset)
            3'd0: rd_data[NSRC-1:0] = pending;
            3'd1: rd_data[NSRC-1:0] = mask;
            3'd3: begin
                rd_data[15]  = in_service;
                rd_data[3:0] = vector;
            end
            3'd4: rd_data[0] = gie;
`ifdef J1_IRQ_TIMER_EN
            3'd5: rd_data = tmr_reload;
            3'd6: rd_data = tmr_count;
`endif
            default: rd_data = 16'h0000;
        endcase
    end

    assign io.din = sel ? rd_data : 16'h0000;
    assign io.sel = sel;

endmodule
